// File: rtl/l15_anycoredecoder_if.sv
`default_nettype none
// ============================================================================
// Module      : l15_anycoredecoder_if
// Description : Bundle of the AnyCore-side request/response handshakes and the
//               L1.5 transducer request bus seen by the request decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface l15_anycoredecoder_if #(
   parameter int PADDR_W = 40
);
   // AnyCore request side
   logic               anycore_ic2mem_reqvalid;
   logic [PADDR_W-1:0] anycore_ic2mem_reqaddr;
   logic               anycore_mem2ic_reqready;
   logic               anycore_dc2mem_ldvalid;
   logic [PADDR_W-1:0] anycore_dc2mem_ldaddr;
   logic               anycore_mem2dc_ldready;
   logic               anycore_dc2mem_stvalid;
   logic [PADDR_W-1:0] anycore_dc2mem_staddr;
   logic [63:0]        anycore_dc2mem_stdata;
   logic [1:0]         anycore_dc2mem_stsize;
   logic               anycore_mem2dc_streqready;
   // Response pulses from the response encoder
   logic               anycore_mem2ic_respvalid;
   logic               anycore_mem2dc_ldvalid;
   logic               anycore_mem2dc_stcomplete;
   // L1.5 transducer request bus
   logic               transducer_l15_val;
   logic [4:0]         transducer_l15_rqtype;
   logic [PADDR_W-1:0] transducer_l15_address;
   logic [2:0]         transducer_l15_size;
   logic [63:0]        transducer_l15_data;
   logic               transducer_l15_nc;
   logic               transducer_l15_threadid;
   logic               l15_transducer_ack;
   // Status
   logic               decoder_err;

   // Decoder view
   modport slave (
      input  anycore_ic2mem_reqvalid, anycore_ic2mem_reqaddr,
      output anycore_mem2ic_reqready,
      input  anycore_dc2mem_ldvalid, anycore_dc2mem_ldaddr,
      output anycore_mem2dc_ldready,
      input  anycore_dc2mem_stvalid, anycore_dc2mem_staddr,
      input  anycore_dc2mem_stdata, anycore_dc2mem_stsize,
      output anycore_mem2dc_streqready,
      input  anycore_mem2ic_respvalid, anycore_mem2dc_ldvalid,
      input  anycore_mem2dc_stcomplete,
      output transducer_l15_val, transducer_l15_rqtype, transducer_l15_address,
      output transducer_l15_size, transducer_l15_data, transducer_l15_nc,
      output transducer_l15_threadid,
      input  l15_transducer_ack,
      output decoder_err
   );

   // Environment view (core + L1.5 + response encoder)
   modport master (
      output anycore_ic2mem_reqvalid, anycore_ic2mem_reqaddr,
      input  anycore_mem2ic_reqready,
      output anycore_dc2mem_ldvalid, anycore_dc2mem_ldaddr,
      input  anycore_mem2dc_ldready,
      output anycore_dc2mem_stvalid, anycore_dc2mem_staddr,
      output anycore_dc2mem_stdata, anycore_dc2mem_stsize,
      input  anycore_mem2dc_streqready,
      output anycore_mem2ic_respvalid, anycore_mem2dc_ldvalid,
      output anycore_mem2dc_stcomplete,
      input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_address,
      input  transducer_l15_size, transducer_l15_data, transducer_l15_nc,
      input  transducer_l15_threadid,
      output l15_transducer_ack,
      input  decoder_err
   );
endinterface
`default_nettype wire

// File: rtl/l15_anycoredecoder.sv
`default_nettype none
// ============================================================================
// Module      : l15_anycoredecoder
// Description : AnyCore -> L1.5 request decoder. One outstanding request per
//               class (I-fill, D-load, D-store), round-robin arbitration onto
//               the single L1.5 request bus, store data converted to
//               big-endian byte-lane-replicated form.
// Revision    : 1.0 - initial release
// ============================================================================
module l15_anycoredecoder #(
   parameter int PADDR_W = 40,
   parameter int DATA_W  = 64
) (
   input  wire logic           clk,
   input  wire logic           rst,
   l15_anycoredecoder_if.slave bus
);

   // L1.5 request type codes
   localparam logic [4:0] C_RQ_LOAD  = 5'b00000;
   localparam logic [4:0] C_RQ_STORE = 5'b00001;
   localparam logic [4:0] C_RQ_IFILL = 5'b10000;
   // L1.5 size codes
   localparam logic [2:0] C_SZ_1B    = 3'b000;
   localparam logic [2:0] C_SZ_2B    = 3'b001;
   localparam logic [2:0] C_SZ_4B    = 3'b010;
   localparam logic [2:0] C_SZ_8B    = 3'b011;
   localparam logic [2:0] C_SZ_16B   = 3'b100;
   localparam logic [2:0] C_SZ_32B   = 3'b101;
   // Class indices, also the round-robin order
   localparam int         C_IC       = 0;
   localparam int         C_LD       = 1;
   localparam int         C_ST       = 2;

   typedef enum logic [1:0] {
      CLS_IDLE = 2'd0,
      CLS_PEND = 2'd1,
      CLS_WAIT = 2'd2
   } cls_state_t;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_REQ  = 1'b1
   } arb_state_t;

   logic [2:0]         w_req_valid;
   logic [2:0]         w_rsp;
   logic [2:0]         w_pend;
   logic [2:0]         w_wait;
   logic [2:0]         w_ready;
   logic [2:0]         w_accept;
   logic [2:0]         w_ack_cls;
   logic [2:0]         w_bad_rsp;
   logic [2:0]         w_elig;
   logic               w_arb_req_ack;

   logic [PADDR_W-1:0] r_ic_addr;
   logic [PADDR_W-1:0] r_ld_addr;
   logic [PADDR_W-1:0] r_st_addr;
   logic [DATA_W-1:0]  r_st_data;
   logic [2:0]         r_st_size;

   logic [DATA_W-1:0]  w_st_swap;
   logic [DATA_W-1:0]  w_st_data_be;
   logic [2:0]         w_st_size_code;

   arb_state_t         r_arb;
   logic [1:0]         r_ptr;
   logic [1:0]         r_gnt;
   logic               r_val;
   logic [4:0]         r_rqtype;
   logic [PADDR_W-1:0] r_addr;
   logic [2:0]         r_size;
   logic [DATA_W-1:0]  r_data;
   logic               r_err;

   logic               w_gnt_found;
   logic [1:0]         w_gnt_idx;
   logic [1:0]         w_cand;
   logic [4:0]         w_sel_rqtype;
   logic [PADDR_W-1:0] w_sel_addr;
   logic [2:0]         w_sel_size;
   logic [DATA_W-1:0]  w_sel_data;

   assign w_req_valid   = {bus.anycore_dc2mem_stvalid, bus.anycore_dc2mem_ldvalid,
                           bus.anycore_ic2mem_reqvalid};
   assign w_rsp         = {bus.anycore_mem2dc_stcomplete, bus.anycore_mem2dc_ldvalid,
                           bus.anycore_mem2ic_respvalid};
   assign w_arb_req_ack = (r_arb == ARB_REQ) && bus.l15_transducer_ack;

   // Per-class request tracker: IDLE -> PEND -> WAIT -> IDLE
   for (genvar gi = 0; gi < 3; gi++) begin : g_cls
      cls_state_t r_state;
      logic       r_ready;

      // Class FSM with registered ready (high exactly while IDLE)
      always_ff @(posedge clk) begin
         if (rst) begin
            r_state <= CLS_IDLE;
            r_ready <= 1'b1;
         end else begin
            case (r_state)
               CLS_IDLE: begin
                  if (w_accept[gi]) begin
                     r_state <= CLS_PEND;
                     r_ready <= 1'b0;
                  end
               end
               CLS_PEND: begin
                  if (w_ack_cls[gi]) begin
                     r_state <= CLS_WAIT;
                  end
               end
               CLS_WAIT: begin
                  if (w_rsp[gi]) begin
                     r_state <= CLS_IDLE;
                     r_ready <= 1'b1;
                  end
               end
               default: begin
                  r_state <= CLS_IDLE;
                  r_ready <= 1'b1;
               end
            endcase
         end
      end

      assign w_ready[gi]   = r_ready;
      assign w_pend[gi]    = (r_state == CLS_PEND);
      assign w_wait[gi]    = (r_state == CLS_WAIT);
      assign w_accept[gi]  = w_req_valid[gi] && r_ready;
      assign w_ack_cls[gi] = w_arb_req_ack && (r_gnt == 2'(gi));
      assign w_bad_rsp[gi] = w_rsp[gi] && (r_state != CLS_WAIT);
   end

   // Store data: byte-reverse to big-endian, then replicate the live bytes
   always_comb begin
      w_st_swap      = '0;
      w_st_data_be   = '0;
      w_st_size_code = C_SZ_1B;
      for (int b = 0; b < 8; b++) begin
         w_st_swap[8*(7-b) +: 8] = bus.anycore_dc2mem_stdata[8*b +: 8];
      end
      case (bus.anycore_dc2mem_stsize)
         2'b00: begin
            w_st_data_be   = {8{w_st_swap[63:56]}};
            w_st_size_code = C_SZ_1B;
         end
         2'b01: begin
            w_st_data_be   = {4{w_st_swap[63:48]}};
            w_st_size_code = C_SZ_2B;
         end
         2'b10: begin
            w_st_data_be   = {2{w_st_swap[63:32]}};
            w_st_size_code = C_SZ_4B;
         end
         default: begin
            w_st_data_be   = w_st_swap;
            w_st_size_code = C_SZ_8B;
         end
      endcase
   end

   // Latch request fields on acceptance, with line alignment applied
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ic_addr <= '0;
         r_ld_addr <= '0;
         r_st_addr <= '0;
         r_st_data <= '0;
         r_st_size <= '0;
      end else begin
         if (w_accept[C_IC]) begin
            r_ic_addr <= bus.anycore_ic2mem_reqaddr & ~PADDR_W'(32'h1F);
         end
         if (w_accept[C_LD]) begin
            r_ld_addr <= bus.anycore_dc2mem_ldaddr & ~PADDR_W'(32'hF);
         end
         if (w_accept[C_ST]) begin
            r_st_addr <= bus.anycore_dc2mem_staddr;
            r_st_data <= w_st_data_be;
            r_st_size <= w_st_size_code;
         end
      end
   end

   // Eligibility: a load may not pass an older store still pending or in flight
   always_comb begin
      w_elig       = w_pend;
      w_elig[C_LD] = w_pend[C_LD] && !(w_pend[C_ST] || w_wait[C_ST]);
   end

   // Round-robin pick starting at the pointer, order IC -> LD -> ST
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_idx   = 2'd0;
      w_cand      = 2'd0;
      for (int k = 0; k < 3; k++) begin
         w_cand = 2'((int'(r_ptr) + k) % 3);
         if (!w_gnt_found && w_elig[w_cand]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = w_cand;
         end
      end
   end

   // Request fields of the selected class
   always_comb begin
      w_sel_rqtype = C_RQ_IFILL;
      w_sel_addr   = r_ic_addr;
      w_sel_size   = C_SZ_32B;
      w_sel_data   = '0;
      case (w_gnt_idx)
         2'd1: begin
            w_sel_rqtype = C_RQ_LOAD;
            w_sel_addr   = r_ld_addr;
            w_sel_size   = C_SZ_16B;
         end
         2'd2: begin
            w_sel_rqtype = C_RQ_STORE;
            w_sel_addr   = r_st_addr;
            w_sel_size   = r_st_size;
            w_sel_data   = r_st_data;
         end
         default: begin
         end
      endcase
   end

   // Arbiter FSM: grant in IDLE, hold the request bus stable until ack
   always_ff @(posedge clk) begin
      if (rst) begin
         r_arb    <= ARB_IDLE;
         r_ptr    <= 2'd0;
         r_gnt    <= 2'd0;
         r_val    <= 1'b0;
         r_rqtype <= '0;
         r_addr   <= '0;
         r_size   <= '0;
         r_data   <= '0;
      end else begin
         case (r_arb)
            ARB_IDLE: begin
               if (w_gnt_found) begin
                  r_arb    <= ARB_REQ;
                  r_gnt    <= w_gnt_idx;
                  r_ptr    <= (w_gnt_idx == 2'd2) ? 2'd0 : w_gnt_idx + 2'd1;
                  r_val    <= 1'b1;
                  r_rqtype <= w_sel_rqtype;
                  r_addr   <= w_sel_addr;
                  r_size   <= w_sel_size;
                  r_data   <= w_sel_data;
               end
            end
            ARB_REQ: begin
               if (bus.l15_transducer_ack) begin
                  r_arb <= ARB_IDLE;
                  r_val <= 1'b0;
               end
            end
         endcase
      end
   end

   // Sticky flag for a response that arrives with no matching request in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (|w_bad_rsp) begin
         r_err <= 1'b1;
      end
   end

   assign bus.anycore_mem2ic_reqready   = w_ready[C_IC];
   assign bus.anycore_mem2dc_ldready    = w_ready[C_LD];
   assign bus.anycore_mem2dc_streqready = w_ready[C_ST];
   assign bus.transducer_l15_val        = r_val;
   assign bus.transducer_l15_rqtype     = r_rqtype;
   assign bus.transducer_l15_address    = r_addr;
   assign bus.transducer_l15_size       = r_size;
   assign bus.transducer_l15_data       = r_data;
   assign bus.transducer_l15_nc         = 1'b0;
   assign bus.transducer_l15_threadid   = 1'b0;
   assign bus.decoder_err               = r_err;

endmodule
`default_nettype wire

// File: tb/tb_l15_anycoredecoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_l15_anycoredecoder
// Description : Directed self-checking bench for l15_anycoredecoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l15_anycoredecoder;

   localparam logic [4:0] C_RQ_LOAD  = 5'b00000;
   localparam logic [4:0] C_RQ_STORE = 5'b00001;
   localparam logic [4:0] C_RQ_IFILL = 5'b10000;
   localparam logic [2:0] C_SZ_16B   = 3'b100;
   localparam logic [2:0] C_SZ_32B   = 3'b101;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   l15_anycoredecoder_if #(.PADDR_W(40)) bus ();

   l15_anycoredecoder #(.PADDR_W(40), .DATA_W(64)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Store vectors: address, little-endian data, size, expected big-endian data, size code
   logic [39:0] st_a   [4] = '{40'h00_0000_1005, 40'h00_0000_2002, 40'h00_0000_3004, 40'h00_0000_4000};
   logic [63:0] st_d   [4] = '{64'h0000_0000_0000_00AB, 64'h0000_0000_0000_BEEF,
                              64'h0000_0000_1122_3344, 64'h0102_0304_0506_0708};
   logic [1:0]  st_s   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
   logic [63:0] st_exp [4] = '{64'hABAB_ABAB_ABAB_ABAB, 64'hEFBE_EFBE_EFBE_EFBE,
                              64'h4433_2211_4433_2211, 64'h0807_0605_0403_0201};
   logic [2:0]  st_sz  [4] = '{3'b000, 3'b001, 3'b010, 3'b011};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.anycore_ic2mem_reqvalid   = 1'b0;
      bus.anycore_ic2mem_reqaddr    = '0;
      bus.anycore_dc2mem_ldvalid    = 1'b0;
      bus.anycore_dc2mem_ldaddr     = '0;
      bus.anycore_dc2mem_stvalid    = 1'b0;
      bus.anycore_dc2mem_staddr     = '0;
      bus.anycore_dc2mem_stdata     = '0;
      bus.anycore_dc2mem_stsize     = '0;
      bus.anycore_mem2ic_respvalid  = 1'b0;
      bus.anycore_mem2dc_ldvalid    = 1'b0;
      bus.anycore_mem2dc_stcomplete = 1'b0;
      bus.l15_transducer_ack        = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_val",   64'(bus.transducer_l15_val), 64'd0);
      check("rst_icrdy", 64'(bus.anycore_mem2ic_reqready), 64'd1);
      check("rst_ldrdy", 64'(bus.anycore_mem2dc_ldready), 64'd1);
      check("rst_strdy", 64'(bus.anycore_mem2dc_streqready), 64'd1);
      check("rst_err",   64'(bus.decoder_err), 64'd0);
      check("rst_nc",    64'(bus.transducer_l15_nc), 64'd0);
      rst = 1'b0;
      tick();

      // I-fill: latency, alignment, hold without ack, release, retire
      bus.anycore_ic2mem_reqvalid = 1'b1;
      bus.anycore_ic2mem_reqaddr  = 40'h00_8000_0013;
      tick();
      bus.anycore_ic2mem_reqvalid = 1'b0;
      check("ic_rdy_low", 64'(bus.anycore_mem2ic_reqready), 64'd0);
      check("ic_val_early", 64'(bus.transducer_l15_val), 64'd0);
      tick();
      check("ic_val",    64'(bus.transducer_l15_val), 64'd1);
      check("ic_rqtype", 64'(bus.transducer_l15_rqtype), 64'(C_RQ_IFILL));
      check("ic_addr",   64'(bus.transducer_l15_address), 64'h00_8000_0000);
      check("ic_size",   64'(bus.transducer_l15_size), 64'(C_SZ_32B));
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ic_hold_val",  64'(bus.transducer_l15_val), 64'd1);
         check("ic_hold_addr", 64'(bus.transducer_l15_address), 64'h00_8000_0000);
      end
      bus.l15_transducer_ack = 1'b1;
      tick();
      bus.l15_transducer_ack = 1'b0;
      check("ic_val_drop", 64'(bus.transducer_l15_val), 64'd0);
      check("ic_rdy_wait", 64'(bus.anycore_mem2ic_reqready), 64'd0);
      bus.anycore_mem2ic_respvalid = 1'b1;
      tick();
      bus.anycore_mem2ic_respvalid = 1'b0;
      check("ic_rdy_back", 64'(bus.anycore_mem2ic_reqready), 64'd1);
      check("ic_err",      64'(bus.decoder_err), 64'd0);

      // Stores of each size: big-endian conversion and replication
      for (int i = 0; i < 4; i++) begin
         bus.anycore_dc2mem_stvalid = 1'b1;
         bus.anycore_dc2mem_staddr  = st_a[i];
         bus.anycore_dc2mem_stdata  = st_d[i];
         bus.anycore_dc2mem_stsize  = st_s[i];
         tick();
         bus.anycore_dc2mem_stvalid = 1'b0;
         tick();
         check("st_val",    64'(bus.transducer_l15_val), 64'd1);
         check("st_rqtype", 64'(bus.transducer_l15_rqtype), 64'(C_RQ_STORE));
         check("st_addr",   64'(bus.transducer_l15_address), 64'(st_a[i]));
         check("st_size",   64'(bus.transducer_l15_size), 64'(st_sz[i]));
         check("st_data",   bus.transducer_l15_data, st_exp[i]);
         bus.l15_transducer_ack = 1'b1;
         tick();
         bus.l15_transducer_ack = 1'b0;
         bus.anycore_mem2dc_stcomplete = 1'b1;
         tick();
         bus.anycore_mem2dc_stcomplete = 1'b0;
         check("st_rdy_back", 64'(bus.anycore_mem2dc_streqready), 64'd1);
      end

      // All three classes at once: IC, then ST, LD held behind the store
      bus.anycore_ic2mem_reqvalid = 1'b1;
      bus.anycore_ic2mem_reqaddr  = 40'h00_0000_0100;
      bus.anycore_dc2mem_ldvalid  = 1'b1;
      bus.anycore_dc2mem_ldaddr   = 40'h00_0000_020F;
      bus.anycore_dc2mem_stvalid  = 1'b1;
      bus.anycore_dc2mem_staddr   = 40'h00_0000_3007;
      bus.anycore_dc2mem_stdata   = 64'h5A;
      bus.anycore_dc2mem_stsize   = 2'b00;
      tick();
      bus.anycore_ic2mem_reqvalid = 1'b0;
      bus.anycore_dc2mem_ldvalid  = 1'b0;
      bus.anycore_dc2mem_stvalid  = 1'b0;
      tick();
      check("rr_first",  64'(bus.transducer_l15_rqtype), 64'(C_RQ_IFILL));
      check("rr_first_v", 64'(bus.transducer_l15_val), 64'd1);
      bus.l15_transducer_ack = 1'b1;
      tick();
      bus.l15_transducer_ack = 1'b0;
      check("rr_gap", 64'(bus.transducer_l15_val), 64'd0);
      tick();
      check("rr_second",   64'(bus.transducer_l15_rqtype), 64'(C_RQ_STORE));
      check("rr_second_v", 64'(bus.transducer_l15_val), 64'd1);
      bus.l15_transducer_ack = 1'b1;
      tick();
      bus.l15_transducer_ack = 1'b0;
      tick();
      tick();
      check("ld_held", 64'(bus.transducer_l15_val), 64'd0);
      bus.anycore_mem2dc_stcomplete = 1'b1;
      tick();
      bus.anycore_mem2dc_stcomplete = 1'b0;
      tick();
      check("rr_third_v", 64'(bus.transducer_l15_val), 64'd1);
      check("rr_third",   64'(bus.transducer_l15_rqtype), 64'(C_RQ_LOAD));
      check("ld_addr",    64'(bus.transducer_l15_address), 64'h00_0000_0200);
      check("ld_size",    64'(bus.transducer_l15_size), 64'(C_SZ_16B));
      bus.l15_transducer_ack = 1'b1;
      tick();
      bus.l15_transducer_ack = 1'b0;
      bus.anycore_mem2ic_respvalid = 1'b1;
      bus.anycore_mem2dc_ldvalid   = 1'b1;
      tick();
      bus.anycore_mem2ic_respvalid = 1'b0;
      bus.anycore_mem2dc_ldvalid   = 1'b0;
      check("rr_icrdy", 64'(bus.anycore_mem2ic_reqready), 64'd1);
      check("rr_ldrdy", 64'(bus.anycore_mem2dc_ldready), 64'd1);
      check("rr_err",   64'(bus.decoder_err), 64'd0);

      // Load response coincident with a new load request
      bus.anycore_dc2mem_ldvalid = 1'b1;
      bus.anycore_dc2mem_ldaddr  = 40'h00_0000_0040;
      tick();
      bus.anycore_dc2mem_ldvalid = 1'b0;
      tick();
      bus.l15_transducer_ack = 1'b1;
      tick();
      bus.l15_transducer_ack = 1'b0;
      bus.anycore_mem2dc_ldvalid = 1'b1;
      bus.anycore_dc2mem_ldvalid = 1'b1;
      bus.anycore_dc2mem_ldaddr  = 40'h00_0000_0088;
      tick();
      bus.anycore_mem2dc_ldvalid = 1'b0;
      check("ldcoll_not_acc", 64'(bus.anycore_mem2dc_ldready), 64'd1);
      tick();
      bus.anycore_dc2mem_ldvalid = 1'b0;
      check("ldcoll_acc", 64'(bus.anycore_mem2dc_ldready), 64'd0);
      check("ldcoll_val0", 64'(bus.transducer_l15_val), 64'd0);
      tick();
      check("ldcoll_val",  64'(bus.transducer_l15_val), 64'd1);
      check("ldcoll_addr", 64'(bus.transducer_l15_address), 64'h00_0000_0080);
      bus.l15_transducer_ack = 1'b1;
      tick();
      bus.l15_transducer_ack = 1'b0;
      bus.anycore_mem2dc_ldvalid = 1'b1;
      tick();
      bus.anycore_mem2dc_ldvalid = 1'b0;
      check("ldcoll_err", 64'(bus.decoder_err), 64'd0);

      // Stray store completion
      bus.anycore_mem2dc_stcomplete = 1'b1;
      tick();
      bus.anycore_mem2dc_stcomplete = 1'b0;
      check("err_set",   64'(bus.decoder_err), 64'd1);
      check("err_strdy", 64'(bus.anycore_mem2dc_streqready), 64'd1);
      check("err_val",   64'(bus.transducer_l15_val), 64'd0);
      tick();
      tick();
      check("err_sticky", 64'(bus.decoder_err), 64'd1);

      // Reset while a request waits for ack
      bus.anycore_ic2mem_reqvalid = 1'b1;
      bus.anycore_ic2mem_reqaddr  = 40'h00_0000_0500;
      tick();
      bus.anycore_ic2mem_reqvalid = 1'b0;
      tick();
      check("mrst_pre_val", 64'(bus.transducer_l15_val), 64'd1);
      rst = 1'b1;
      tick();
      check("mrst_val",   64'(bus.transducer_l15_val), 64'd0);
      check("mrst_icrdy", 64'(bus.anycore_mem2ic_reqready), 64'd1);
      check("mrst_ldrdy", 64'(bus.anycore_mem2dc_ldready), 64'd1);
      check("mrst_strdy", 64'(bus.anycore_mem2dc_streqready), 64'd1);
      check("mrst_err",   64'(bus.decoder_err), 64'd0);
      rst = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
